// File: rtl/ahb_default_slave_v2_pkg.sv
// -----------------------------------------------------------------------------
// ahb_default_slave_v2_pkg
//   Shared AHB definitions for the default-slave slice: HTRANS and HRESP
//   encodings plus the default-slave FSM state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package ahb_default_slave_v2_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ERR1 = 3'd2,
    ST_ERR2 = 3'd3,
    ST_RAZ  = 3'd4
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave_v2_if.sv
// -----------------------------------------------------------------------------
// ahb_default_slave_v2_if
//   AHB slave-side signal bundle for the default slave.
//   slave modport : hsel, hreadyin, haddr, htrans, hwrite, hsize, hburst,
//                   hwdata, hmaster, hmastlock in; hreadyout, hresp, hrdata,
//                   hsplit out.
//   master modport: the mirror image.
// -----------------------------------------------------------------------------
interface ahb_default_slave_v2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic              hreadyin;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic [3:0]        hmaster;
  logic              hmastlock;
  logic              hreadyout;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;
  logic [15:0]       hsplit;

  modport slave (
    input  hsel, hreadyin, haddr, htrans, hwrite, hsize, hburst,
           hwdata, hmaster, hmastlock,
    output hreadyout, hresp, hrdata, hsplit
  );

  modport master (
    output hsel, hreadyin, haddr, htrans, hwrite, hsize, hburst,
           hwdata, hmaster, hmastlock,
    input  hreadyout, hresp, hrdata, hsplit
  );
endinterface

// File: rtl/ahb_default_slave_v2_errlog.sv
// -----------------------------------------------------------------------------
// ahb_ds_errlog
//   Sticky log of the first transfer accepted by the default slave.
//   Ports: HCLK, HRESETn (async, active-low); capture (accepted transfer),
//   addr/master/write (address-phase info); err_clr (clear request);
//   err_valid, err_addr, err_master, err_write, err_ovf (log outputs).
//   A capture arriving while the log is full only raises err_ovf; a capture
//   coinciding with err_clr replaces the entry and leaves err_ovf low.
// -----------------------------------------------------------------------------
module ahb_ds_errlog #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              capture,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        master,
  input  logic              write,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [3:0]        err_master,
  output logic              err_write,
  output logic              err_ovf
);
  logic              valid_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        master_reg;
  logic              write_reg;
  logic              ovf_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_reg  <= 1'b0;
      addr_reg   <= '0;
      master_reg <= '0;
      write_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (capture && (!valid_reg || err_clr)) begin
      valid_reg  <= 1'b1;
      addr_reg   <= addr;
      master_reg <= master;
      write_reg  <= write;
      ovf_reg    <= 1'b0;
    end else if (capture) begin
      ovf_reg    <= 1'b1;
    end else if (err_clr) begin
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end
  end

  assign err_valid  = valid_reg;
  assign err_addr   = addr_reg;
  assign err_master = master_reg;
  assign err_write  = write_reg;
  assign err_ovf    = ovf_reg;
endmodule

// File: rtl/ahb_default_slave_v2.sv
// -----------------------------------------------------------------------------
// ahb_default_slave_v2
//   AHB default slave for unmapped regions. Every accepted NONSEQ/SEQ gets
//   WAIT_CYCLES wait states, then either a two-cycle ERROR (ERR_MODE=1) or a
//   single OKAY beat returning RAZ_VALUE on reads (ERR_MODE=0). Outputs are
//   decoded from registered state only. DATA_W must be 32 or 64,
//   WAIT_CYCLES 0..15.
//   Ports: HCLK, HRESETn (async, active-low), bus (ahb_default_slave_v2_if
//   slave modport). With AHB_DS_ERRLOG_EN defined, adds err_valid, err_addr,
//   err_master, err_write, err_ovf (out) and err_clr (in).
// -----------------------------------------------------------------------------
module ahb_default_slave_v2
  import ahb_default_slave_v2_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              WAIT_CYCLES = 0,
  parameter int              ERR_MODE    = 1,
  parameter logic [DATA_W-1:0] RAZ_VALUE = '0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_default_slave_v2_if.slave bus
`ifdef AHB_DS_ERRLOG_EN
  ,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [3:0]        err_master,
  output logic              err_write,
  output logic              err_ovf,
  input  logic              err_clr
`endif
);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam ds_state_t  ST_RESP   = (ERR_MODE != 0) ? ST_ERR1 : ST_RAZ;
  localparam ds_state_t  ST_FIRST  = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;

  ds_state_t  state_reg, state_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic       write_reg, write_next;
  logic       accept;
  logic       take;

  logic              hreadyout_dec;
  logic [1:0]        hresp_dec;
  logic [DATA_W-1:0] hrdata_dec;

  assign accept = bus.hsel & bus.hreadyin & bus.htrans[1];

  // A new address phase can only be taken in the states that drive
  // HREADYOUT high; in WAIT/ERR1 the bus is stalled by this slave.
  assign take = accept & ((state_reg == ST_IDLE) || (state_reg == ST_ERR2) ||
                          (state_reg == ST_RAZ));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 4'd0;
      write_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      write_reg    <= write_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    write_next    = write_reg;
    case (state_reg)
      ST_IDLE, ST_ERR2, ST_RAZ: begin
        if (take) begin
          state_next    = ST_FIRST;
          wait_cnt_next = WAIT_LOAD;
          write_next    = bus.hwrite;
        end else begin
          state_next    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == 4'd0) state_next = ST_RESP;
        else                      wait_cnt_next = wait_cnt_reg - 4'd1;
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout_dec = 1'b1;
    hresp_dec     = HRESP_OKAY;
    hrdata_dec    = '0;
    case (state_reg)
      ST_WAIT: hreadyout_dec = 1'b0;
      ST_ERR1: begin
        hreadyout_dec = 1'b0;
        hresp_dec     = HRESP_ERROR;
      end
      ST_ERR2: hresp_dec = HRESP_ERROR;
      ST_RAZ:  if (!write_reg) hrdata_dec = RAZ_VALUE;
      default: ;
    endcase
  end

  assign bus.hreadyout = hreadyout_dec;
  assign bus.hresp     = hresp_dec;
  assign bus.hrdata    = hrdata_dec;
  assign bus.hsplit    = 16'h0000;

`ifdef AHB_DS_ERRLOG_EN
  ahb_ds_errlog #(.ADDR_W(ADDR_W)) u_errlog (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .capture    (take),
    .addr       (bus.haddr),
    .master     (bus.hmaster),
    .write      (bus.hwrite),
    .err_clr    (err_clr),
    .err_valid  (err_valid),
    .err_addr   (err_addr),
    .err_master (err_master),
    .err_write  (err_write),
    .err_ovf    (err_ovf)
  );

  logic unused_inputs;
  assign unused_inputs = ^{bus.hsize, bus.hburst, bus.hwdata, bus.hmastlock};
`else
  // Address-phase attributes do not influence the response.
  logic unused_inputs;
  assign unused_inputs = ^{bus.hsize, bus.hburst, bus.hwdata, bus.hmastlock,
                           bus.haddr, bus.hmaster};
`endif
endmodule

// File: tb/tb_ahb_default_slave_v2.sv
// -----------------------------------------------------------------------------
// tb_ahb_default_slave_v2
//   Three default-slave instances: 0 = no waits/ERROR, 1 = 3 waits/ERROR,
//   2 = no waits/RAZ (0xDEADBEEF). Expected per-cycle responses are queued
//   when a transfer is driven and compared as each cycle completes.
// -----------------------------------------------------------------------------
module tb_ahb_default_slave_v2;
  import ahb_default_slave_v2_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    int          dut;
    string       tag;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]  sel;
  logic        hrdy_in;
  logic [1:0]  trans;
  logic        wr;
  logic [31:0] addr;
  logic [3:0]  mst;
  logic [2:0]  sz, bst;
  logic [31:0] wdata;
  logic        lock;
  logic        err_clr;

  logic        rdy_o   [3];
  logic [1:0]  resp_o  [3];
  logic [31:0] rdata_o [3];
  logic [15:0] split_o [3];
  logic        lg_valid  [3];
  logic [31:0] lg_addr   [3];
  logic [3:0]  lg_master [3];
  logic        lg_write  [3];
  logic        lg_ovf    [3];

  ahb_default_slave_v2_if #(.ADDR_W(32), .DATA_W(32)) bus [3] ();

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    assign bus[gi].hsel      = sel[gi];
    assign bus[gi].hreadyin  = hrdy_in;
    assign bus[gi].haddr     = addr;
    assign bus[gi].htrans    = trans;
    assign bus[gi].hwrite    = wr;
    assign bus[gi].hsize     = sz;
    assign bus[gi].hburst    = bst;
    assign bus[gi].hwdata    = wdata;
    assign bus[gi].hmaster   = mst;
    assign bus[gi].hmastlock = lock;
    assign rdy_o[gi]   = bus[gi].hreadyout;
    assign resp_o[gi]  = bus[gi].hresp;
    assign rdata_o[gi] = bus[gi].hrdata;
    assign split_o[gi] = bus[gi].hsplit;

    ahb_default_slave_v2 #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .WAIT_CYCLES ((gi == 1) ? 3 : 0),
      .ERR_MODE    ((gi == 2) ? 0 : 1),
      .RAZ_VALUE   ((gi == 2) ? 32'hDEAD_BEEF : 32'h0)
    ) u_dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus[gi])
`ifdef AHB_DS_ERRLOG_EN
      ,
      .err_valid  (lg_valid[gi]),
      .err_addr   (lg_addr[gi]),
      .err_master (lg_master[gi]),
      .err_write  (lg_write[gi]),
      .err_ovf    (lg_ovf[gi]),
      .err_clr    (err_clr)
`endif
    );
`ifndef AHB_DS_ERRLOG_EN
    assign lg_valid[gi]  = 1'b0;
    assign lg_addr[gi]   = 32'h0;
    assign lg_master[gi] = 4'h0;
    assign lg_write[gi]  = 1'b0;
    assign lg_ovf[gi]    = 1'b0;
`endif
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Drive one address phase; d < 0 deselects every instance.
  task automatic drive(input int d, input logic [1:0] tr, input logic w,
                       input logic [31:0] a, input logic [3:0] m, input logic r);
    sel     = (d >= 0) ? (3'b001 << d) : 3'b000;
    trans   = tr;
    wr      = w;
    addr    = a;
    mst     = m;
    hrdy_in = r;
    sz      = 3'($urandom_range(0, 2));
    bst     = 3'($urandom_range(0, 7));
    wdata   = $urandom;
    lock    = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input int d, input string tag, input logic r,
                      input logic [1:0] resp, input logic [31:0] rd);
    exp_t e;
    e.dut = d; e.tag = tag; e.rdy = r; e.resp = resp; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge HCLK);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "/rdy"},   64'(rdy_o[e.dut]),   64'(e.rdy));
      chk({e.tag, "/resp"},  64'(resp_o[e.dut]),  64'(e.resp));
      chk({e.tag, "/rdata"}, 64'(rdata_o[e.dut]), 64'(e.rdata));
    end
  endtask

  initial begin
    err_clr = 1'b0;
    drive(-1, HTRANS_IDLE, 1'b0, 32'h0, 4'h0, 1'b1);
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d/rdy", i),   64'(rdy_o[i]),   64'd1);
      chk($sformatf("reset%0d/resp", i),  64'(resp_o[i]),  64'(HRESP_OKAY));
      chk($sformatf("reset%0d/rdata", i), 64'(rdata_o[i]), 64'd0);
      chk($sformatf("reset%0d/split", i), 64'(split_o[i]), 64'd0);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;

    // IDLE transfers with HSEL high
    for (int i = 0; i < 3; i++) begin
      drive(0, HTRANS_IDLE, 1'b0, 32'h0, 4'h0, 1'b1);
      push(0, $sformatf("idle%0d", i), 1'b1, HRESP_OKAY, 32'h0);
      tick();
    end

    // Single NONSEQ read, zero waits; IDLE in ERR2 gets OKAY next
    drive(0, HTRANS_NONSEQ, 1'b0, 32'h4000_0000, 4'h1, 1'b1);
    push(0, "rd_err1", 1'b0, HRESP_ERROR, 32'h0);
    push(0, "rd_err2", 1'b1, HRESP_ERROR, 32'h0);
    push(0, "rd_done", 1'b1, HRESP_OKAY,  32'h0);
    tick();
    drive(0, HTRANS_IDLE, 1'b0, 32'h0, 4'h1, 1'b0);
    tick();
    drive(0, HTRANS_IDLE, 1'b0, 32'h0, 4'h1, 1'b1);
    tick();

    // NONSEQ write with three wait states
    drive(1, HTRANS_NONSEQ, 1'b1, 32'h5000_0010, 4'h3, 1'b1);
    for (int i = 0; i < 3; i++) push(1, $sformatf("w3_wait%0d", i), 1'b0, HRESP_OKAY, 32'h0);
    push(1, "w3_err1", 1'b0, HRESP_ERROR, 32'h0);
    push(1, "w3_err2", 1'b1, HRESP_ERROR, 32'h0);
    push(1, "w3_done", 1'b1, HRESP_OKAY,  32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, HTRANS_IDLE, 1'b0, 32'h0, 4'h3, 1'b0);
      tick();
    end
    drive(1, HTRANS_IDLE, 1'b0, 32'h0, 4'h3, 1'b1);
    tick();

    // Back-to-back errors, then SEQ with HREADYIN low must be ignored
    drive(0, HTRANS_NONSEQ, 1'b0, 32'h6000_0000, 4'h2, 1'b1);
    push(0, "b2b_a_err1", 1'b0, HRESP_ERROR, 32'h0);
    push(0, "b2b_a_err2", 1'b1, HRESP_ERROR, 32'h0);
    push(0, "b2b_b_err1", 1'b0, HRESP_ERROR, 32'h0);
    push(0, "b2b_b_err2", 1'b1, HRESP_ERROR, 32'h0);
    push(0, "seq_nrdy0",  1'b1, HRESP_OKAY,  32'h0);
    push(0, "seq_nrdy1",  1'b1, HRESP_OKAY,  32'h0);
    tick();
    drive(0, HTRANS_IDLE, 1'b0, 32'h0, 4'h2, 1'b0);
    tick();
    drive(0, HTRANS_NONSEQ, 1'b1, 32'h6000_0004, 4'h2, 1'b1);
    tick();
    drive(0, HTRANS_IDLE, 1'b0, 32'h0, 4'h2, 1'b0);
    tick();
    drive(0, HTRANS_SEQ, 1'b0, 32'h6000_0008, 4'h2, 1'b0);
    tick();
    drive(0, HTRANS_SEQ, 1'b0, 32'h6000_000C, 4'h2, 1'b0);
    tick();

    // RAZ/WI: read, SEQ read, write, idle
    drive(2, HTRANS_NONSEQ, 1'b0, 32'h7000_0000, 4'h4, 1'b1);
    push(2, "raz_rd",   1'b1, HRESP_OKAY, 32'hDEAD_BEEF);
    push(2, "raz_rd2",  1'b1, HRESP_OKAY, 32'hDEAD_BEEF);
    push(2, "raz_wr",   1'b1, HRESP_OKAY, 32'h0);
    push(2, "raz_idle", 1'b1, HRESP_OKAY, 32'h0);
    tick();
    drive(2, HTRANS_SEQ, 1'b0, 32'h7000_0004, 4'h4, 1'b1);
    tick();
    drive(2, HTRANS_NONSEQ, 1'b1, 32'h7000_0008, 4'h4, 1'b1);
    tick();
    drive(2, HTRANS_IDLE, 1'b0, 32'h0, 4'h4, 1'b1);
    tick();

    // Reset in the middle of a waited response; nothing resumes afterwards
    drive(1, HTRANS_NONSEQ, 1'b0, 32'h5000_0100, 4'h6, 1'b1);
    push(1, "rst_pre", 1'b0, HRESP_OKAY, 32'h0);
    tick();
    drive(1, HTRANS_IDLE, 1'b0, 32'h0, 4'h6, 1'b0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_mid/rdy",  64'(rdy_o[1]),  64'd1);
    chk("rst_mid/resp", 64'(resp_o[1]), 64'(HRESP_OKAY));
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(1, HTRANS_IDLE, 1'b0, 32'h0, 4'h6, 1'b1);
    push(1, "rst_post0", 1'b1, HRESP_OKAY, 32'h0);
    push(1, "rst_post1", 1'b1, HRESP_OKAY, 32'h0);
    tick();
    tick();

`ifdef AHB_DS_ERRLOG_EN
    // Error log: first entry kept, second raises overflow, clear empties it
    drive(-1, HTRANS_IDLE, 1'b0, 32'h0, 4'h0, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("log_clr0/valid", 64'(lg_valid[0]), 64'd0);
    drive(0, HTRANS_NONSEQ, 1'b0, 32'h0000_0100, 4'h2, 1'b1);
    tick();
    chk("log_first/valid",  64'(lg_valid[0]),  64'd1);
    chk("log_first/addr",   64'(lg_addr[0]),   64'h100);
    chk("log_first/master", 64'(lg_master[0]), 64'd2);
    chk("log_first/ovf",    64'(lg_ovf[0]),    64'd0);
    drive(0, HTRANS_IDLE, 1'b0, 32'h0, 4'h2, 1'b0);
    tick();
    drive(0, HTRANS_NONSEQ, 1'b1, 32'h0000_0200, 4'h5, 1'b1);
    tick();
    chk("log_second/addr",   64'(lg_addr[0]),   64'h100);
    chk("log_second/master", 64'(lg_master[0]), 64'd2);
    chk("log_second/ovf",    64'(lg_ovf[0]),    64'd1);
    drive(0, HTRANS_IDLE, 1'b0, 32'h0, 4'h5, 1'b0);
    tick();
    drive(0, HTRANS_IDLE, 1'b0, 32'h0, 4'h5, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("log_clr1/valid", 64'(lg_valid[0]), 64'd0);
    chk("log_clr1/ovf",   64'(lg_ovf[0]),   64'd0);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
